// File: rtl/rf_param.sv
// Parameterised 2-read / 2-write register file that self-clears after reset (INIT) before going usable (RUN).
// Reads are combinational with optional same-cycle write forwarding; ready is registered.
module rf_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_enabled,
    input  logic [ADDR_W-1:0] rd2,
    input  logic [DATA_W-1:0] write_data2,
    input  logic              write_enabled2,
    output logic [DATA_W-1:0] outA,
    output logic [DATA_W-1:0] outB,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr1_ok;
    logic wr2_ok;

    // Address 0 is never a legal write target when hardwired to zero.
    assign wr1_ok = write_enabled  && !(ZERO_REG && rd  == '0);
    assign wr2_ok = write_enabled2 && !(ZERO_REG && rd2 == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Port 2 is assigned last so it wins an address collision with port 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[cnt] <= '0;
            end else begin
                if (wr1_ok) mem[rd]  <= write_data;
                if (wr2_ok) mem[rd2] <= write_data2;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (!reset && state == RUN && !(ZERO_REG && addr == '0)) begin
            if (BYPASS && wr2_ok && rd2 == addr)
                val = write_data2;
            else if (BYPASS && wr1_ok && rd == addr)
                val = write_data;
            else
                val = mem[addr];
        end
        return val;
    endfunction

    always_comb begin
        outA = read_port(rs);
        outB = read_port(rt);
    end

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: default, no-bypass and narrow (16x8) instances.
module tb_rf_param;

    logic        clk;
    logic        reset;
    logic [4:0]  rs, rt, rd, rd2;
    logic [31:0] write_data, write_data2;
    logic        write_enabled, write_enabled2;
    logic [31:0] outA, outB, nb_outA, nb_outB;
    logic        ready, nb_ready;

    logic        s_reset;
    logic [2:0]  s_rs, s_rt, s_rd, s_rd2;
    logic [15:0] s_wdata, s_wdata2;
    logic        s_we, s_we2;
    logic [15:0] s_outA, s_outB;
    logic        s_ready;

    int checks;
    int failures;

    rf_param u_dut (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd), .write_data(write_data),
        .write_enabled(write_enabled), .rd2(rd2), .write_data2(write_data2),
        .write_enabled2(write_enabled2), .outA(outA), .outB(outB), .ready(ready)
    );

    rf_param #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd), .write_data(write_data),
        .write_enabled(write_enabled), .rd2(rd2), .write_data2(write_data2),
        .write_enabled2(write_enabled2), .outA(nb_outA), .outB(nb_outB), .ready(nb_ready)
    );

    rf_param #(.DATA_W(16), .ADDR_W(3)) u_small (
        .clk(clk), .reset(s_reset), .rs(s_rs), .rt(s_rt), .rd(s_rd), .write_data(s_wdata),
        .write_enabled(s_we), .rd2(s_rd2), .write_data2(s_wdata2),
        .write_enabled2(s_we2), .outA(s_outA), .outB(s_outB), .ready(s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises on each instance; 0 means it never rose.
    task automatic wait_ready(input bit init_write, output int n_main, output int n_small);
        n_main  = 0;
        n_small = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (init_write && i == 10) begin
                write_enabled = 1'b0;
                check("init_outA_zero", outA, 32'h0);
            end
            if (init_write && i == 9) begin
                rd = 5'd3; rs = 5'd3; write_data = 32'h3333_3333; write_enabled = 1'b1;
            end
            if (ready && n_main == 0) n_main = i;
            if (s_ready && n_small == 0) n_small = i;
            if (n_main != 0 && (n_small != 0 || !init_write)) break;
        end
    endtask

    initial begin
        int nm, ns;
        checks = 0; failures = 0;
        reset = 1'b1; s_reset = 1'b1;
        rs = '0; rt = '0; rd = '0; rd2 = '0;
        write_data = '0; write_data2 = '0; write_enabled = 1'b0; write_enabled2 = 1'b0;
        s_rs = '0; s_rt = '0; s_rd = '0; s_rd2 = '0;
        s_wdata = '0; s_wdata2 = '0; s_we = 1'b0; s_we2 = 1'b0;

        tick();
        tick();
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_outA", outA, 32'h0);
        reset = 1'b0; s_reset = 1'b0;

        wait_ready(1'b1, nm, ns);
        check("ready_edges", 32'(nm), 32'd32);
        check("nb_ready", 32'(nb_ready), 32'h1);
        check("small_ready_edges", 32'(ns), 32'd8);

        for (int a = 0; a < 32; a++) begin
            rs = 5'(a); rt = 5'(a);
            #1;
            check("clear_outA", outA, 32'h0);
            check("clear_outB", outB, 32'h0);
        end
        rs = 5'd3; #1;
        check("init_write_ignored", outA, 32'h0);

        // Zero register
        rd = 5'd0; rs = 5'd0; write_data = 32'hDEAD_BEEF; write_enabled = 1'b1;
        #1;
        check("zero_same_cycle", outA, 32'h0);
        tick();
        write_enabled = 1'b0; #1;
        check("zero_next_cycle", outA, 32'h0);

        // Bypass vs no-bypass
        rd = 5'd5; rs = 5'd5; write_data = 32'h1111_1111; write_enabled = 1'b1;
        #1;
        check("bypass_same_cycle", outA, 32'h1111_1111);
        check("nobypass_same_cycle", nb_outA, 32'h0);
        tick();
        write_enabled = 1'b0; #1;
        check("bypass_next", outA, 32'h1111_1111);
        check("nobypass_next", nb_outA, 32'h1111_1111);
        rt = 5'd5; #1;
        check("same_addr_outB", outB, 32'h1111_1111);

        // Dual-write conflict
        rd = 5'd7; rd2 = 5'd7; rt = 5'd7;
        write_data = 32'hAAAA_AAAA; write_data2 = 32'h5555_5555;
        write_enabled = 1'b1; write_enabled2 = 1'b1;
        #1;
        check("conflict_bypass", outB, 32'h5555_5555);
        tick();
        write_enabled = 1'b0; write_enabled2 = 1'b0; #1;
        check("conflict_stored", outB, 32'h5555_5555);
        check("conflict_stored_nb", nb_outB, 32'h5555_5555);

        // Parallel writes
        rd = 5'd8; rd2 = 5'd9; write_data = 32'h1; write_data2 = 32'h2;
        write_enabled = 1'b1; write_enabled2 = 1'b1;
        tick();
        write_enabled = 1'b0; write_enabled2 = 1'b0;
        rs = 5'd8; rt = 5'd9; #1;
        check("parallel_p1", outA, 32'h1);
        check("parallel_p2", outB, 32'h2);

        // Narrow instance
        s_rd = 3'd7; s_wdata = 16'hFFFF; s_we = 1'b1;
        tick();
        s_we = 1'b0; s_rs = 3'd7; #1;
        check("small_r7", 32'(s_outA), 32'h0000_FFFF);

        // Reset mid-RUN
        rd = 5'd3; write_data = 32'h2222_2222; write_enabled = 1'b1;
        tick();
        write_enabled = 1'b0; rs = 5'd3; #1;
        check("r3_written", outA, 32'h2222_2222);
        reset = 1'b1; #1;
        check("reset_outA_gated", outA, 32'h0);
        tick();
        check("reset_drops_ready", 32'(ready), 32'h0);
        reset = 1'b0;
        wait_ready(1'b0, nm, ns);
        check("rerun_ready_edges", 32'(nm), 32'd32);
        #1;
        check("r3_recleared", outA, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
